// File: rtl/cap_sensor_scan.sv
// cap_sensor_scan: round-robin capacitive touch-pad scanner.
// Each pad is discharged, then driven high. The scanner counts clock cycles until
// the synchronized pad input reads high and compares that charge time against a
// threshold to form a per-pad touched flag.
//
// Ports:
//   clock, reset_n   system clock, asynchronous active-low reset
//   enable, start    scanner enable and single-cycle scan request
//   sensor_in        raw asynchronous pad inputs (one bit per pad)
//   sensor_drive     pad drive, one-hot during CHARGE, 0 otherwise
//   busy             scan in progress
//   scan_done        one-cycle pulse when the last channel is stored
//   sample_valid     one-cycle pulse per channel measurement
//   sample_ch/_count/_timeout   last measurement, held until the next one
//   touched          registered per-pad touch flags
//
// Optional feature: define CAP_SCAN_BASELINE_EN to keep a per-channel baseline
// and make THRESHOLD a delta above it instead of an absolute count.
module cap_sensor_scan #(
    parameter int unsigned NUM_CH           = 4,
    parameter int unsigned CNT_W            = 16,
    parameter int unsigned DISCHARGE_CYCLES = 64,
    parameter int unsigned MAX_COUNT        = 50000,
    parameter int unsigned THRESHOLD        = 200,
    parameter int unsigned CONTINUOUS       = 0,
    localparam int unsigned CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              start,
    input  logic [NUM_CH-1:0] sensor_in,
    output logic [NUM_CH-1:0] sensor_drive,
    output logic              busy,
    output logic              scan_done,
    output logic              sample_valid,
    output logic [CH_W-1:0]   sample_ch,
    output logic [CNT_W-1:0]  sample_count,
    output logic              sample_timeout,
    output logic [NUM_CH-1:0] touched
);
    localparam int unsigned DIS_W = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
    localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(DISCHARGE_CYCLES - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {S_IDLE, S_DISCHARGE, S_CHARGE, S_STORE} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DIS_W-1:0]  dis_q, dis_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic              sync_in;
    logic              at_max;
    logic [NUM_CH-1:0] drive_d, touched_d;
    logic              busy_d, done_d, valid_d, timeout_d;
    logic [CH_W-1:0]   sch_d;
    logic [CNT_W-1:0]  scnt_d;

`ifdef CAP_SCAN_BASELINE_EN
    logic [CNT_W-1:0]  base_q [NUM_CH];
    logic [CNT_W-1:0]  base_d [NUM_CH];
    logic [NUM_CH-1:0] base_vld_q, base_vld_d;
`endif

    assign sync_in = sync2_q[ch_q];
    // Timeout fires on the increment that would take the count to MAX_COUNT.
    assign at_max  = !sync_in && (count_q == MAX_CNT - CNT_W'(1));

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        dis_d     = dis_q;
        count_d   = count_q;
        drive_d   = '0;
        busy_d    = busy;
        done_d    = 1'b0;
        valid_d   = 1'b0;
        sch_d     = sample_ch;
        scnt_d    = sample_count;
        timeout_d = sample_timeout;
        touched_d = touched;
`ifdef CAP_SCAN_BASELINE_EN
        base_d     = base_q;
        base_vld_d = base_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable && (start || CONTINUOUS != 0)) begin
                    state_d = S_DISCHARGE;
                    ch_d    = '0;
                    dis_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_DISCHARGE: begin
                if (dis_q == DIS_LAST) begin
                    state_d = S_CHARGE;
                    count_d = '0;
                    drive_d = NUM_CH'(1) << ch_q;
                end else begin
                    dis_d = dis_q + DIS_W'(1);
                end
            end
            S_CHARGE: begin
                if (sync_in || at_max) begin
                    state_d   = S_STORE;
                    valid_d   = 1'b1;
                    sch_d     = ch_q;
                    scnt_d    = at_max ? MAX_CNT : count_q;
                    count_d   = at_max ? MAX_CNT : count_q;
                    timeout_d = at_max;
                    done_d    = (ch_q == LAST_CH);
`ifdef CAP_SCAN_BASELINE_EN
                    if (at_max) begin
                        touched_d[ch_q] = 1'b0;
                    end else if (!base_vld_q[ch_q]) begin
                        base_d[ch_q]     = count_q;
                        base_vld_d[ch_q] = 1'b1;
                        touched_d[ch_q]  = 1'b0;
                    end else begin
                        touched_d[ch_q] = ({1'b0, count_q} >=
                                           ({1'b0, base_q[ch_q]} + (CNT_W+1)'(THRESHOLD)));
                    end
`else
                    touched_d[ch_q] = !at_max && (count_q >= CNT_W'(THRESHOLD));
`endif
                end else begin
                    count_d = count_q + CNT_W'(1);
                    drive_d = sensor_drive;
                end
            end
            S_STORE: begin
                dis_d = '0;
                if (ch_q == LAST_CH) begin
                    if (CONTINUOUS != 0 && enable) begin
                        state_d = S_DISCHARGE;
                        ch_d    = '0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    state_d = S_DISCHARGE;
                    ch_d    = ch_q + CH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, synchronizer and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            ch_q           <= '0;
            dis_q          <= '0;
            count_q        <= '0;
            sync1_q        <= '0;
            sync2_q        <= '0;
            sensor_drive   <= '0;
            busy           <= 1'b0;
            scan_done      <= 1'b0;
            sample_valid   <= 1'b0;
            sample_ch      <= '0;
            sample_count   <= '0;
            sample_timeout <= 1'b0;
            touched        <= '0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            dis_q          <= dis_d;
            count_q        <= count_d;
            sync1_q        <= sensor_in;
            sync2_q        <= sync1_q;
            sensor_drive   <= drive_d;
            busy           <= busy_d;
            scan_done      <= done_d;
            sample_valid   <= valid_d;
            sample_ch      <= sch_d;
            sample_count   <= scnt_d;
            sample_timeout <= timeout_d;
            touched        <= touched_d;
        end
    end

`ifdef CAP_SCAN_BASELINE_EN
    // Per-channel baseline storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_vld_q <= '0;
            for (int i = 0; i < NUM_CH; i++) base_q[i] <= '0;
        end else begin
            base_vld_q <= base_vld_d;
            base_q     <= base_d;
        end
    end
`endif

endmodule

// File: tb/tb_cap_sensor_scan.sv
// tb_cap_sensor_scan: directed bench for cap_sensor_scan.
// Pads are modelled as rising a programmable number of cycles after their drive
// goes high (negative = never). Expected samples are derived from that delay and
// checked against a queue on every sample_valid.
module tb_cap_sensor_scan;
    localparam int NCH  = 4;
    localparam int DC   = 8;
    localparam int MAXC = 1000;
    localparam int TH   = 100;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    // Instance A: one scan per start pulse.
    logic           enable_a, start_a, busy_a, done_a, sv_a, sto_a;
    logic [NCH-1:0] sensor_a, drive_a, touched_a;
    logic [1:0]     sch_a;
    logic [15:0]    scnt_a;
    // Instance B: continuous rescan, two pads.
    logic           enable_b, start_b, busy_b, done_b, sv_b, sto_b, sch_b;
    logic [1:0]     sensor_b, drive_b, touched_b;
    logic [15:0]    scnt_b;

    cap_sensor_scan #(.NUM_CH(NCH), .CNT_W(16), .DISCHARGE_CYCLES(DC), .MAX_COUNT(MAXC),
                      .THRESHOLD(TH), .CONTINUOUS(0)) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(enable_a), .start(start_a),
        .sensor_in(sensor_a), .sensor_drive(drive_a), .busy(busy_a), .scan_done(done_a),
        .sample_valid(sv_a), .sample_ch(sch_a), .sample_count(scnt_a),
        .sample_timeout(sto_a), .touched(touched_a));

    cap_sensor_scan #(.NUM_CH(2), .CNT_W(16), .DISCHARGE_CYCLES(DC), .MAX_COUNT(MAXC),
                      .THRESHOLD(TH), .CONTINUOUS(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(enable_b), .start(start_b),
        .sensor_in(sensor_b), .sensor_drive(drive_b), .busy(busy_b), .scan_done(done_b),
        .sample_valid(sv_b), .sample_ch(sch_b), .sample_count(scnt_b),
        .sample_timeout(sto_b), .touched(touched_b));

    // Pad models: age = cycles the drive has been high.
    int dly_a [NCH];
    int age_a [NCH];
    int dly_b [2];
    int age_b [2];
    always @(posedge clock) begin
        for (int i = 0; i < NCH; i++) age_a[i] <= drive_a[i] ? age_a[i] + 1 : 0;
        for (int i = 0; i < 2; i++)   age_b[i] <= drive_b[i] ? age_b[i] + 1 : 0;
    end
    always_comb begin
        for (int i = 0; i < NCH; i++)
            sensor_a[i] = drive_a[i] && (dly_a[i] >= 0) && (age_a[i] >= dly_a[i]);
        for (int i = 0; i < 2; i++)
            sensor_b[i] = drive_b[i] && (dly_b[i] >= 0) && (age_b[i] >= dly_b[i]);
    end

    int total = 0;
    int bad   = 0;
    task automatic check(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Two synchronizer stages add two cycles; reaching MAX_COUNT is a timeout.
    function automatic bit exp_to(input int d);
        return (d < 0) || (d + 2 >= MAXC);
    endfunction
    function automatic int exp_cnt(input int d);
        return exp_to(d) ? MAXC : d + 2;
    endfunction

    typedef struct { int ch; int cnt; bit to; } samp_t;
    samp_t          q_a [$];
    samp_t          e;
    logic [NCH-1:0] mt_a = '0;
`ifdef CAP_SCAN_BASELINE_EN
    int base_m [NCH];
    bit bv_m   [NCH];
`endif

    task automatic push_scan_a(input int upto);
        samp_t s;
        for (int c = 0; c < upto; c++) begin
            s.ch = c; s.cnt = exp_cnt(dly_a[c]); s.to = exp_to(dly_a[c]);
            q_a.push_back(s);
        end
    endtask

    task automatic model_reset();
        mt_a = '0;
`ifdef CAP_SCAN_BASELINE_EN
        for (int i = 0; i < NCH; i++) begin base_m[i] = 0; bv_m[i] = 1'b0; end
`endif
    endtask

    function automatic void model_touch(input samp_t s);
        bit t;
`ifdef CAP_SCAN_BASELINE_EN
        if (s.to) t = 1'b0;
        else if (!bv_m[s.ch]) begin base_m[s.ch] = s.cnt; bv_m[s.ch] = 1'b1; t = 1'b0; end
        else t = (s.cnt >= base_m[s.ch] + TH);
`else
        t = !s.to && (s.cnt >= TH);
`endif
        mt_a[s.ch] = t;
    endfunction

    // Instance B model state.
    int b_ch = 0, b_samples = 0, b_dones = 0;

    // Compare process.
    always @(negedge clock) begin
        if (reset_n) begin
            check("a_drive_onehot", int'((drive_a == '0) || (busy_a && $onehot(drive_a))), 1);
            if (sv_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_sample", int'(sch_a), -1);
                end else begin
                    e = q_a.pop_front();
                    check("a_ch", int'(sch_a), e.ch);
                    check("a_count", int'(scnt_a), e.cnt);
                    check("a_timeout", int'(sto_a), int'(e.to));
                    check("a_done", int'(done_a), int'(e.ch == NCH - 1));
                    model_touch(e);
                    check("a_touched", int'(touched_a), int'(mt_a));
                end
            end else begin
                check("a_done_idle", int'(done_a), 0);
            end
            if (sv_b) begin
                check("b_ch", int'(sch_b), b_ch);
                check("b_count", int'(scnt_b), exp_cnt(dly_b[b_ch]));
                check("b_done", int'(done_b), int'(b_ch == 1));
                b_ch = 1 - b_ch;
                b_samples++;
                if (done_b) b_dones++;
            end
        end
    end

    task automatic pulse_start_a();
        @(posedge clock); #1 start_a = 1'b1;
        @(posedge clock); #1 start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, input string tag);
        int n = 0;
        while (!done_a && n < budget) begin @(negedge clock); n++; end
        check({tag, "_done_seen"}, int'(done_a), 1);
        check({tag, "_busy_at_done"}, int'(busy_a), 1);
        @(negedge clock);
        check({tag, "_busy_after"}, int'(busy_a), 0);
        check({tag, "_all_samples"}, q_a.size(), 0);
    endtask

    task automatic run_scan_a(input int budget, input string tag);
        push_scan_a(NCH);
        pulse_start_a();
        wait_done_a(budget, tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    int'(busy_a), 0);
        check({tag, "_valid"},   int'(sv_a), 0);
        check({tag, "_done"},    int'(done_a), 0);
        check({tag, "_drive"},   int'(drive_a), 0);
        check({tag, "_touched"}, int'(touched_a), 0);
        check({tag, "_count"},   int'(scnt_a), 0);
        check({tag, "_ch"},      int'(sch_a), 0);
        check({tag, "_timeout"}, int'(sto_a), 0);
    endtask

    initial begin
        int n;
        enable_a = 1'b0; start_a = 1'b0; enable_b = 1'b0; start_b = 1'b0;
        dly_a = '{50, 150, 50, 50};
        dly_b = '{5, 20};
        model_reset();
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        enable_a = 1'b1;

        // Basic scan with fixed latency to the first sample.
        push_scan_a(NCH);
        pulse_start_a();
        check("s1_busy_rise", int'(busy_a), 1);
        n = 0;
        while (!sv_a && n < 200) begin @(negedge clock); n++; end
        check("s1_first_sample_latency", n, 62);
        wait_done_a(2000, "s1");
`ifndef CAP_SCAN_BASELINE_EN
        check("s1_touched_lit", int'(touched_a), 4'b0010);
`endif
        check("s1_count_held", int'(scnt_a), 52);

        // Pad 3 never rises.
        dly_a = '{50, 50, 50, -1};
        run_scan_a(3000, "s2");
        check("s2_timeout_lit", int'(sto_a), 1);
        check("s2_count_lit", int'(scnt_a), 1000);
`ifndef CAP_SCAN_BASELINE_EN
        check("s2_touched_lit", int'(touched_a), 4'b0000);
`endif

        // Threshold boundary: 2 / 100 / 99 / 202.
        dly_a = '{0, 98, 97, 200};
        run_scan_a(2000, "s3");
`ifndef CAP_SCAN_BASELINE_EN
        check("s3_touched_lit", int'(touched_a), 4'b1010);
`endif
        check("s3_count_lit", int'(scnt_a), 202);

        // start while busy is ignored.
        dly_a = '{10, 10, 10, 10};
        push_scan_a(NCH);
        pulse_start_a();
        repeat (30) @(posedge clock);
        pulse_start_a();
        wait_done_a(1000, "s4");
        repeat (100) @(posedge clock);
        check("s4_no_rescan", int'(busy_a), 0);

        // start with enable low is ignored.
        enable_a = 1'b0;
        pulse_start_a();
        repeat (40) @(posedge clock);
        check("s5_disabled_idle", int'(busy_a), 0);
        enable_a = 1'b1;

        // Continuous instance: drop enable partway through the fourth scan.
        #1 enable_b = 1'b1;
        n = 0;
        while (b_dones < 3 && n < 2000) begin @(negedge clock); n++; end
        check("b_three_scans", b_dones, 3);
        repeat (10) @(posedge clock);
        #1 enable_b = 1'b0;
        check("b_busy_mid_scan", int'(busy_b), 1);
        n = 0;
        while (busy_b && n < 2000) begin @(negedge clock); n++; end
        check("b_scans_total", b_dones, 4);
        check("b_samples_total", b_samples, 8);
        repeat (50) @(posedge clock);
        check("b_stays_idle", int'(busy_b), 0);
        check("b_no_more_scans", b_dones, 4);
        check("b_touched_lit", int'(touched_b), 0);

        // Reset during CHARGE of channel 2.
        dly_a = '{50, 50, 50, 50};
        push_scan_a(2);
        pulse_start_a();
        n = 0;
        while (!drive_a[2] && n < 1000) begin @(negedge clock); n++; end
        check("s6_charging_ch2", int'(drive_a), 4'b0100);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_all_zero("s6_reset");
        check("s6_samples_before_reset", q_a.size(), 0);
        model_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
        run_scan_a(2000, "s7");
        check("s7_count_lit", int'(scnt_a), 52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
